// File: rtl/twiddle_stage.sv
// Twiddle stage: counter-driven twiddle addressing and a two-register complex multiply.
// Define TWIDDLE_STAGE_ROUND_EN for round-half-up with saturation; default truncates (floor).
module twiddle_stage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned TW_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [6:0]       tw_addr,
  input  logic [WIDTH-1:0] tw_re,
  input  logic [WIDTH-1:0] tw_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam int unsigned PW = 2 * WIDTH + 1;

  // Stage-1 alignment assumes the table answers exactly one cycle after tw_addr.
  if (TW_LAT != 1) begin : gen_lat_check
    $error("twiddle_stage: only TW_LAT = 1 is supported");
  end

  logic [6:0]       cnt_q, cnt_d;
  logic [6:0]       cnt_lo;
  logic [WIDTH-1:0] s1_re_q, s1_im_q;
  logic             s1_en_q, s1_byp_q;
  logic             do_en_q;
  logic [WIDTH-1:0] do_re_q, do_re_d;
  logic [WIDTH-1:0] do_im_q, do_im_d;
  logic [WIDTH-1:0] res_re, res_im;

  assign cnt_d  = di_en ? cnt_q + 7'd1 : cnt_q;
  assign cnt_lo = {2'b00, cnt_q[4:0]};

  // Multiplier M = 0,2,1,3 selected by the bit-reversed upper counter bits.
  always_comb begin
    tw_addr = 7'd0;
    unique case (cnt_q[6:5])
      2'b00:   tw_addr = 7'd0;
      2'b01:   tw_addr = cnt_lo << 1;
      2'b10:   tw_addr = cnt_lo;
      2'b11:   tw_addr = (cnt_lo << 1) + cnt_lo;
      default: tw_addr = 7'd0;
    endcase
  end

  logic signed [PW-1:0] a_re, a_im, w_re, w_im;
  logic signed [PW-1:0] prod_re, prod_im;

  assign a_re = PW'(signed'(s1_re_q));
  assign a_im = PW'(signed'(s1_im_q));
  assign w_re = PW'(signed'(tw_re));
  assign w_im = PW'(signed'(tw_im));

  assign prod_re = a_re * w_re - a_im * w_im;
  assign prod_im = a_re * w_im + a_im * w_re;

`ifdef TWIDDLE_STAGE_ROUND_EN
  localparam logic signed [PW-1:0] RndBias = PW'(1) << (WIDTH - 2);

  logic signed [PW-1:0] sh_re, sh_im;

  function automatic logic [WIDTH-1:0] sat(input logic [PW-1:0] v);
    logic [PW-WIDTH:0] top;
    top = v[PW-1:WIDTH-1];
    if (&top || ~|top) begin
      return v[WIDTH-1:0];
    end
    return v[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign sh_re  = (prod_re + RndBias) >>> (WIDTH - 1);
  assign sh_im  = (prod_im + RndBias) >>> (WIDTH - 1);
  assign res_re = sat(sh_re);
  assign res_im = sat(sh_im);
`else
  logic unused_prod;

  // Arithmetic shift by WIDTH-1 then keep the low WIDTH bits.
  assign res_re = prod_re[2*WIDTH-2:WIDTH-1];
  assign res_im = prod_im[2*WIDTH-2:WIDTH-1];
  assign unused_prod = ^{prod_re[PW-1:2*WIDTH-1], prod_re[WIDTH-2:0],
                         prod_im[PW-1:2*WIDTH-1], prod_im[WIDTH-2:0]};
`endif

  always_comb begin
    do_re_d = res_re;
    do_im_d = res_im;
    if (s1_byp_q) begin
      do_re_d = s1_re_q;
      do_im_d = s1_im_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
      s1_en_q  <= 1'b0;
      s1_byp_q <= 1'b0;
      do_en_q  <= 1'b0;
      do_re_q  <= '0;
      do_im_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      s1_re_q  <= di_re;
      s1_im_q  <= di_im;
      s1_en_q  <= di_en;
      s1_byp_q <= (tw_addr == 7'd0);
      do_en_q  <= s1_en_q;
      do_re_q  <= do_re_d;
      do_im_q  <= do_im_d;
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;

endmodule

// File: tb/tb_twiddle_stage.sv
// Directed bench for twiddle_stage: reset, address sequence, bypass, multiply, rounding,
// gapped input and mid-frame reset. Twiddle table is modelled with one cycle of latency.
module tb_twiddle_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        di_en = 1'b0;
  logic [15:0] di_re = '0;
  logic [15:0] di_im = '0;
  logic [6:0]  tw_addr;
  logic [15:0] tw_re, tw_im;
  logic        do_en;
  logic [15:0] do_re, do_im;

  logic [15:0] tab_re [0:127];
  logic [15:0] tab_im [0:127];

  int          n_vec = 0;
  int          n_err = 0;
  logic        pend_en = 1'b0, exp_en = 1'b0;
  logic [15:0] pend_re = '0, pend_im = '0, exp_re = '0, exp_im = '0;
  logic [6:0]  addr_seen = '0;
  logic [6:0]  m_cnt = '0;

  twiddle_stage dut (
    .clock   (clock),
    .reset   (reset),
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .tw_addr (tw_addr),
    .tw_re   (tw_re),
    .tw_im   (tw_im),
    .do_en   (do_en),
    .do_re   (do_re),
    .do_im   (do_im)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    tw_re <= tab_re[tw_addr];
    tw_im <= tab_im[tw_addr];
  end

  function automatic logic [6:0] exp_addr(input logic [6:0] c);
    int m;
    case (c[6:5])
      2'b00:   m = 0;
      2'b01:   m = 2;
      2'b10:   m = 1;
      default: m = 3;
    endcase
    return 7'(int'(c[4:0]) * m);
  endfunction

  // Apply one input slot; the output seen after the edge belongs to the previous slot.
  task automatic drive(input logic en, input logic [15:0] re, input logic [15:0] im,
                       input logic [15:0] ore, input logic [15:0] oim);
    di_en = en;
    di_re = re;
    di_im = im;
    #1;
    addr_seen = tw_addr;
    @(posedge clock);
    #1;
    exp_en  = pend_en;
    exp_re  = pend_re;
    exp_im  = pend_im;
    pend_en = en;
    pend_re = ore;
    pend_im = oim;
    if (en) m_cnt = m_cnt + 7'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    di_en = 1'b1;
    di_re = 16'h7777;
    di_im = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      n_vec++;
      if (do_en !== 1'b0 || do_re !== 16'h0 || do_im !== 16'h0 || tw_addr !== 7'd0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: en=%b re=%h im=%h addr=%0d, want 0 0 0 0",
                 i, do_en, do_re, do_im, tw_addr);
      end
    end
    reset = 1'b0;
    m_cnt = '0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (do_en !== 1'b0 || do_re !== 16'h0 || do_im !== 16'h0 || addr_seen !== 7'd0) begin
        n_err++;
        $display("FAIL reset_after[%0d]: en=%b re=%h im=%h addr=%0d, want 0 0 0 0",
                 i, do_en, do_re, do_im, addr_seen);
      end
    end
  endtask

  task automatic test_addr_seq();
    logic [6:0] c;
    for (int i = 0; i < 128; i++) begin
      c = m_cnt;
      drive(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (addr_seen !== exp_addr(c)) begin
        n_err++;
        $display("FAIL addr_seq cnt=%0d: got %0d want %0d", c, addr_seen, exp_addr(c));
      end
      n_vec++;
      if (do_en !== exp_en || (exp_en && {do_re, do_im} !== {exp_re, exp_im})) begin
        n_err++;
        $display("FAIL addr_seq out[%0d]: en=%b re=%h im=%h want en=%b re=%h im=%h",
                 i, do_en, do_re, do_im, exp_en, exp_re, exp_im);
      end
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 16'h1234, 16'h8765, 16'h1234, 16'h8765);
      n_vec++;
      if (addr_seen !== 7'd0) begin
        n_err++;
        $display("FAIL bypass addr[%0d]: got %0d want 0", i, addr_seen);
      end
      n_vec++;
      if (do_en !== exp_en || (exp_en && {do_re, do_im} !== {exp_re, exp_im})) begin
        n_err++;
        $display("FAIL bypass out[%0d]: en=%b re=%h im=%h want en=%b re=%h im=%h",
                 i, do_en, do_re, do_im, exp_en, exp_re, exp_im);
      end
    end
  endtask

  task automatic test_multiply();
    while (m_cnt != 7'd80) begin
      drive(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (do_en !== exp_en || (exp_en && {do_re, do_im} !== {exp_re, exp_im})) begin
        n_err++;
        $display("FAIL mult_fill: en=%b re=%h im=%h want en=%b re=%h im=%h",
                 do_en, do_re, do_im, exp_en, exp_re, exp_im);
      end
    end
    drive(1'b1, 16'h4000, 16'h0000, 16'h2D41, 16'hD2BF);
    n_vec++;
    if (addr_seen !== 7'd16) begin
      n_err++;
      $display("FAIL mult addr: got %0d want 16", addr_seen);
    end
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    n_vec++;
    if (do_en !== 1'b1 || do_re !== 16'h2D41 || do_im !== 16'hD2BF) begin
      n_err++;
      $display("FAIL mult out: en=%b re=%h im=%h want en=1 re=2d41 im=d2bf",
               do_en, do_re, do_im);
    end
  endtask

  task automatic test_rounding();
    logic [15:0] want_re, want_im;
`ifdef TWIDDLE_STAGE_ROUND_EN
    want_re = 16'h0001;
    want_im = 16'h0000;
`else
    want_re = 16'h0000;
    want_im = 16'hFFFF;
`endif
    while (m_cnt != 7'd65) begin
      drive(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (do_en !== exp_en || (exp_en && {do_re, do_im} !== {exp_re, exp_im})) begin
        n_err++;
        $display("FAIL round_fill: en=%b re=%h im=%h want en=%b re=%h im=%h",
                 do_en, do_re, do_im, exp_en, exp_re, exp_im);
      end
    end
    drive(1'b1, 16'h0001, 16'h0000, want_re, want_im);
    n_vec++;
    if (addr_seen !== 7'd1) begin
      n_err++;
      $display("FAIL round addr: got %0d want 1", addr_seen);
    end
    drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    n_vec++;
    if (do_en !== 1'b1 || do_re !== want_re || do_im !== want_im) begin
      n_err++;
      $display("FAIL round out: en=%b re=%h im=%h want en=1 re=%h im=%h",
               do_en, do_re, do_im, want_re, want_im);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] c;
    for (int i = 0; i < 128; i++) begin
      c = m_cnt;
      drive(~i[0], 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (addr_seen !== exp_addr(c)) begin
        n_err++;
        $display("FAIL gaps addr[%0d] cnt=%0d: got %0d want %0d", i, c, addr_seen, exp_addr(c));
      end
      n_vec++;
      if (do_en !== exp_en || (!exp_en && $isunknown({do_re, do_im}))) begin
        n_err++;
        $display("FAIL gaps out[%0d]: en=%b re=%h im=%h want en=%b", i, do_en, do_re, do_im,
                 exp_en);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [6:0] c;
    for (int i = 0; i <= 50; i++) begin
      drive(1'b1, 16'h1234, 16'h8765, 16'h0, 16'h0);
    end
    reset = 1'b1;
    di_en = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    pend_en = 1'b0;
    m_cnt   = '0;
    n_vec++;
    if (do_en !== 1'b0 || do_re !== 16'h0 || do_im !== 16'h0 || tw_addr !== 7'd0) begin
      n_err++;
      $display("FAIL midreset hold: en=%b re=%h im=%h addr=%0d want 0 0 0 0",
               do_en, do_re, do_im, tw_addr);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (do_en !== 1'b0) begin
        n_err++;
        $display("FAIL midreset flush[%0d]: do_en got %b want 0", i, do_en);
      end
    end
    for (int i = 0; i < 34; i++) begin
      c = m_cnt;
      drive(1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
      n_vec++;
      if (addr_seen !== exp_addr(c) || c !== 7'(i)) begin
        n_err++;
        $display("FAIL midreset addr[%0d]: got %0d want %0d", i, addr_seen, exp_addr(7'(i)));
      end
    end
    n_vec++;
    if (addr_seen !== 7'd2) begin
      n_err++;
      $display("FAIL midreset cnt33 addr: got %0d want 2", addr_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      tab_re[i] = 16'h0;
      tab_im[i] = 16'h0;
    end
    tab_re[0]  = 16'h7FFF;
    tab_re[1]  = 16'h7FD9;
    tab_im[1]  = 16'hF9B8;
    tab_re[16] = 16'h5A82;
    tab_im[16] = 16'hA57E;

    test_reset();
    test_addr_seq();
    test_bypass();
    test_multiply();
    test_rounding();
    test_gaps();
    test_mid_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/twiddle_stage.md
TWIDDLE_STAGE -- requirements
Module: twiddle_stage

Interface
REQ-001 Parameter WIDTH, 16, signed data and twiddle width (two's complement, Q1.15 twiddle).
REQ-002 Parameter TW_LAT, 1, twiddle table output latency in cycles; 1 is the only supported value.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  master clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 di_en  input  1  input sample valid.
REQ-007 di_re  input  WIDTH  input sample, real part.
REQ-008 di_im  input  WIDTH  input sample, imaginary part.
REQ-009 tw_addr  output  7  twiddle factor number driven to the 128-point twiddle table.
REQ-010 tw_re  input  WIDTH  twiddle real part, returned by the table TW_LAT cycles after tw_addr.
REQ-011 tw_im  input  WIDTH  twiddle imaginary part, same timing as tw_re.
REQ-012 do_en  output  1  output sample valid.
REQ-013 do_re  output  WIDTH  twiddled output, real part.
REQ-014 do_im  output  WIDTH  twiddled output, imaginary part.

Function
REQ-015 7-bit sample counter cnt; increments by 1 on each clock with di_en=1; holds otherwise; wraps 127 -> 0.
REQ-016 tw_addr combinational from current cnt: cnt[4:0] x M, M = 0,2,1,3 for cnt[6:5] = 00,01,10,11 (bit-reversed select); maximum value 93.
REQ-017 Stage 1 register (every clock): captures di_re, di_im, di_en and flag byp = (tw_addr==0); aligns with registered twiddle.
REQ-018 Stage 2 register (every clock): if stage-1 byp=1, do_re/do_im = stage-1 data unchanged; else full-precision complex product re = a_re*tw_re - a_im*tw_im, im = a_re*tw_im + a_im*tw_re (2*WIDTH+1 bits), scaled by arithmetic shift right WIDTH-1.
REQ-019 Latency: sample accepted at cycle t appears with do_en=1 at cycle t+2; do_en is di_en delayed 2 cycles exactly.
REQ-020 Gaps in di_en: pipeline keeps advancing; do_en=0 for gap slots; twiddle assignment unaffected (driven only by cnt).
REQ-021 do_re/do_im when do_en=0: don't-care, but never X after reset.
REQ-022 No backpressure; block accepts one sample per clock continuously.

Reset
REQ-023 While reset=1: cnt=0, stage-1 and stage-2 registers=0, do_en=0, do_re=0, do_im=0, tw_addr=0.
REQ-024 Reset mid-frame: in-flight samples discarded (do_en=0 for the two cycles after reset deasserts unless new di_en); first sample after reset uses cnt=0.
REQ-025 reset=1 with di_en=1 in the same cycle: reset wins, sample dropped.

Configuration
REQ-026 Macro TWIDDLE_STAGE_ROUND_EN defined: add 2^(WIDTH-2) before the shift, then saturate to 0x7FFF / 0x8000.
REQ-027 Macro undefined: plain truncation (floor), result takes low WIDTH bits after shift, no saturation; bypass path identical in both builds.

Verification
REQ-028 Reset: hold reset 3 cycles with di_en=1 -> do_en=0, do_re=do_im=0, tw_addr=0 throughout and 2 cycles after.
REQ-029 Address sequence: 128 contiguous samples -> tw_addr 0 for cnt 0..32, 2 at cnt 33, 1 at cnt 65, 3 at cnt 97, 93 at cnt 127, 0 at next cnt 0.
REQ-030 Bypass: cnt 0..31 with di=0x1234+j0x8765 -> do identical, do_en 2 cycles after di_en.
REQ-031 Multiply: di=0x4000+j0 at cnt 80 (addr 16, tw=0x5A82/0xA57E) -> do_re=0x2D41, do_im=0xD2BF in both builds.
REQ-032 Rounding: di=0x0001+j0 at cnt 65 (addr 1, tw=0x7FD9/0xF9B8) -> without macro do=0x0000+j0xFFFF; with macro do=0x0001+j0x0000.
REQ-033 Gaps and mid-frame reset: di_en alternating 1/0 for 64 samples -> same tw_addr per sample as contiguous; then reset after sample 50 -> next sample gets tw_addr=0 and counter restarts.
